approx_iter_mult: RTL

- Parametrised, sequential successor to the flat partitioned multiplier slices.
- Computes an unsigned W x W -> 2W product one partial product per clock using shift-add.
- Runtime-selectable column truncation gives approximate results at lower switching activity. With trunc=0 the result is exact.
- Sits behind a valid/ready handshake, so approximate-computing experiments can swap it in for the combinational multiplier partitions.

---
 rtl/approx_iter_mult.sv | 116 +++++++++++
 1 files changed

// File: rtl/approx_iter_mult.sv
`default_nettype none
// ============================================================================
// Module      : approx_iter_mult
// Description : Sequential shift-add W x W -> 2W unsigned multiplier with
//               runtime column truncation behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_iter_mult #(
    parameter int W          = 16,
    parameter int TRW        = $clog2(2*W),
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TRW-1:0]   trunc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q;
    logic [TRW-1:0]   trunc_q;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*W-1:0]   product_q;
    logic             out_valid_q;

    logic [2*W-1:0]   w_mask;
    logic [2*W-1:0]   w_pp;
    logic [CW:0]      w_next_idx;
    logic             w_last;
    logic             w_rest_zero;

    // Shift amounts at or beyond 2W give an all-zero mask, so the result is 0.
    assign w_mask      = {(2*W){1'b1}} << trunc_q;
    assign w_pp        = ({{W{1'b0}}, a_q} << count_q) & w_mask;
    assign w_next_idx  = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
    assign w_last      = (count_q == CW'(W-1));
    assign w_rest_zero = ((b_q >> w_next_idx) == '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            S_BUSY: begin
                acc_d   = acc_q + (b_q[count_q] ? w_pp : '0);
                count_d = count_q + CW'(1);
                if (w_last || ((EARLY_EXIT != 0) && w_rest_zero)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            trunc_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= (state_d == S_DONE);
            if (state_q == S_IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b;
                trunc_q <= trunc;
            end
            // Result is captured once and then held through DONE and IDLE.
            if (state_q == S_BUSY && state_d == S_DONE) begin
                product_q <= acc_d;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
`default_nettype wire
